// File: rtl/chacha20_pkg.sv
// Shared definitions for the ChaCha20 block sequencer and its round core:
// FSM encoding, round count, counter reset value and the "expand 32-byte k" words.
package chacha20_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_OUT   = 3'd4,
    ST_DONE  = 3'd5
  } seq_state_t;

  localparam int CHACHA_ROUNDS = 20;
  localparam int CTR_RESET_VAL = 1;

  // Element [0] is the first state word, 0x61707865 ("expa").
  localparam logic [3:0][31:0] CHACHA_CONST = {
    32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865
  };

endpackage

// File: rtl/chacha20_block_sequencer_if.sv
// Host command, core control and keystream handshake signals of the block sequencer.
// master = the sequencer, slave = host/core/downstream side.
interface chacha20_block_sequencer_if #(
  parameter int CTR_W  = 32,
  parameter int NBLK_W = 16
);
  logic              start;
  logic [NBLK_W-1:0] num_blocks;
  logic              ctr_load;
  logic [CTR_W-1:0]  ctr_init;
  logic              abort;
  logic              core_load;
  logic              core_round_en;
  logic              core_diag;
  logic              core_finalize;
  logic [CTR_W-1:0]  block_ctr;
  logic              ks_valid;
  logic              ks_ready;
  logic              busy;
  logic              done;
  logic              ctr_overflow;

  modport master (
    input  start, num_blocks, ctr_load, ctr_init, abort, ks_ready,
    output core_load, core_round_en, core_diag, core_finalize, block_ctr,
           ks_valid, busy, done, ctr_overflow
  );

  modport slave (
    output start, num_blocks, ctr_load, ctr_init, abort, ks_ready,
    input  core_load, core_round_en, core_diag, core_finalize, block_ctr,
           ks_valid, busy, done, ctr_overflow
  );
endinterface

// File: rtl/chacha20_block_ctr.sv
// ChaCha20 block counter: resets to 1, synchronous load has priority over increment,
// wraps modulo 2^CTR_W and flags the all-ones value.
module chacha20_block_ctr
  import chacha20_pkg::*;
#(
  parameter int CTR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  input  logic             inc,
  output logic [CTR_W-1:0] value,
  output logic             wrap
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= CTR_W'(CTR_RESET_VAL);
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      value <= value + CTR_W'(1);
    end
  end

  assign wrap = &value;

endmodule

// File: rtl/chacha20_block_sequencer.sv
// Control FSM for one iterative ChaCha20 block core: steps load, ROUNDS rounds and the
// feed-forward add per block, then hands each block downstream over valid/ready.
module chacha20_block_sequencer
  import chacha20_pkg::*;
#(
  parameter int CTR_W  = 32,
  parameter int NBLK_W = 16,
  parameter int ROUNDS = CHACHA_ROUNDS
) (
  input logic                        clk,
  input logic                        rst,
  chacha20_block_sequencer_if.master bus
);

  // state    | meaning
  // ST_IDLE  | waiting for start; counter may be preloaded
  // ST_LOAD  | core loads key, nonce and block_ctr
  // ST_ROUND | one column/diagonal round per cycle, ROUNDS cycles
  // ST_FINAL | core adds input state to working state
  // ST_OUT   | keystream block offered until ks_ready
  // ST_DONE  | one-cycle done pulse, then back to idle

  localparam int RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  seq_state_t        state, state_nxt;
  logic [RND_W-1:0]  rnd_left, rnd_left_nxt;
  logic [NBLK_W-1:0] blk_left, blk_left_nxt;
  logic              ovf, ovf_nxt;
  logic              ctr_ld, ctr_inc, ctr_wrap;
  logic [CTR_W-1:0]  ctr_val;

  chacha20_block_ctr #(.CTR_W(CTR_W)) u_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ctr_ld),
    .load_val (bus.ctr_init),
    .inc      (ctr_inc),
    .value    (ctr_val),
    .wrap     (ctr_wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      rnd_left <= '0;
      blk_left <= '0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_nxt;
      rnd_left <= rnd_left_nxt;
      blk_left <= blk_left_nxt;
      ovf      <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rnd_left_nxt = rnd_left;
    blk_left_nxt = blk_left;
    ovf_nxt      = ovf;
    ctr_ld       = 1'b0;
    ctr_inc      = 1'b0;

    if (bus.abort) begin
      state_nxt    = ST_IDLE;
      blk_left_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ctr_ld = bus.ctr_load;
          if (bus.start && (bus.num_blocks != '0)) begin
            blk_left_nxt = bus.num_blocks;
            ovf_nxt      = 1'b0;
            state_nxt    = ST_LOAD;
          end
        end
        ST_LOAD: begin
          rnd_left_nxt = RND_W'(ROUNDS - 1);
          state_nxt    = ST_ROUND;
        end
        ST_ROUND: begin
          if (rnd_left == '0) begin
            state_nxt = ST_FINAL;
          end else begin
            rnd_left_nxt = rnd_left - RND_W'(1);
          end
        end
        ST_FINAL: begin
          state_nxt = ST_OUT;
        end
        ST_OUT: begin
          if (bus.ks_ready) begin
            ctr_inc      = 1'b1;
            blk_left_nxt = blk_left - NBLK_W'(1);
            if (blk_left == NBLK_W'(1)) begin
              state_nxt = ST_DONE;
            end else if (ctr_wrap) begin
              // Another block would reuse a counter value: stop without done.
              ovf_nxt   = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              state_nxt = ST_LOAD;
            end
          end
        end
        ST_DONE: begin
          state_nxt = ST_IDLE;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Round index r = ROUNDS-1-rnd_left; with ROUNDS even, r[0] is the inverse of rnd_left[0].
  assign bus.core_load     = (state == ST_LOAD);
  assign bus.core_round_en = (state == ST_ROUND);
  assign bus.core_diag     = (state == ST_ROUND) && !rnd_left[0];
  assign bus.core_finalize = (state == ST_FINAL);
  assign bus.ks_valid      = (state == ST_OUT);
  assign bus.busy          = (state != ST_IDLE);
  assign bus.done          = (state == ST_DONE);
  assign bus.block_ctr     = ctr_val;
  assign bus.ctr_overflow  = ovf;

endmodule

// File: tb/tb_chacha20_block_sequencer.sv
// Self-checking bench for chacha20_block_sequencer: directed table, hand-written corner
// sequences, and randomized runs against a transaction-level counter model.
module tb_chacha20_block_sequencer;
  localparam int CTR_W  = 32;
  localparam int NBLK_W = 16;
  localparam int ROUNDS = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  chacha20_block_sequencer_if #(.CTR_W(CTR_W), .NBLK_W(NBLK_W)) bus ();

  chacha20_block_sequencer #(.CTR_W(CTR_W), .NBLK_W(NBLK_W), .ROUNDS(ROUNDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q_got[$];
  logic [31:0] exp_q[$];
  int          done_cnt, done_cyc, end_cyc, v_first;
  logic        exp_ovf;
  logic [31:0] exp_final;
  logic [31:0] model_ctr;

  typedef struct {
    logic        pre;
    logic [31:0] init;
    logic [15:0] nblk;
    int          stall;
    int          exp_n;
    logic [31:0] exp_first;
    logic [31:0] exp_final;
    logic        exp_ovf;
    int          exp_done_cyc;
    int          exp_end_cyc;
    int          exp_vfirst;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected delivered counters, overflow flag and final counter of one run.
  function automatic void model_run(input logic [31:0] start_ctr, input int n);
    logic [31:0] c;
    c = start_ctr;
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(c);
      if ((i < n - 1) && (c == 32'hFFFF_FFFF)) begin
        exp_ovf = 1'b1;
        c = c + 32'd1;
        break;
      end
      c = c + 32'd1;
    end
    exp_final = c;
  endfunction

  task automatic drive_run(input logic pre, input logic [31:0] init, input logic [15:0] nblk,
                           input int ready_pct, input int stall_first);
    int          cyc, stalls, load_cyc, nrnd, ndiag, vstart;
    logic [31:0] load_ctr;
    q_got.delete();
    done_cnt = 0; done_cyc = -1; end_cyc = -1; v_first = 0;
    bus.start = 1'b1; bus.num_blocks = nblk; bus.ctr_load = pre; bus.ctr_init = init;
    bus.ks_ready = 1'b0;
    step();
    bus.start = 1'b0; bus.ctr_load = 1'b0;
    cyc = 1; stalls = stall_first; load_cyc = 0; nrnd = 0; ndiag = 0; vstart = -1; load_ctr = '0;
    while (cyc < 2000) begin
      if (!bus.busy) begin
        end_cyc = cyc;
        break;
      end
      if (bus.ks_valid && stalls > 0) begin
        bus.ks_ready = 1'b0;
        stalls--;
      end else begin
        bus.ks_ready = ($urandom_range(99) < ready_pct);
      end
      if (bus.core_load) begin
        load_ctr = bus.block_ctr; load_cyc = cyc; nrnd = 0; ndiag = 0; vstart = -1;
      end
      if (bus.core_round_en) begin
        nrnd++;
        if (bus.core_diag) ndiag++;
      end
      if (bus.core_finalize) check("ctr_stable_final", bus.block_ctr, load_ctr);
      if (bus.ks_valid) begin
        if (vstart < 0) begin
          vstart = cyc;
          check("valid_latency", 32'(vstart - load_cyc), 32'(ROUNDS + 2));
          check("rounds_per_block", 32'(nrnd), 32'(ROUNDS));
          check("diag_rounds", 32'(ndiag), 32'(ROUNDS / 2));
        end
        check("ctr_stable_out", bus.block_ctr, load_ctr);
        if (q_got.size() == 0) v_first++;
        if (bus.ks_ready) q_got.push_back(bus.block_ctr);
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      step();
      cyc++;
    end
    bus.ks_ready = 1'b0;
    if (end_cyc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_timeout: busy still 1 after %0d cycles, expected idle", cyc);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  exp_vec, got_vec;
    logic [31:0] init;
    logic        pre;
    int          n, pct;

    //           pre   init           nblk stall n  first          final          ovf done end vfirst
    vecs[0] = '{1'b0, 32'h0,          16'd2, 5, 2, 32'h2,          32'h4,         1'b0, 52, 53, 6};
    vecs[1] = '{1'b1, 32'h10,         16'd3, 0, 3, 32'h10,         32'h13,        1'b0, 70, 71, 1};
    vecs[2] = '{1'b1, 32'hFFFF_FFFF,  16'd2, 0, 1, 32'hFFFF_FFFF,  32'h0,         1'b1, -1, 24, 1};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF,  16'd1, 0, 1, 32'hFFFF_FFFF,  32'h0,         1'b0, 24, 25, 1};
    vecs[4] = '{1'b1, 32'hFFFF_FFFE,  16'd3, 0, 2, 32'hFFFF_FFFE,  32'h0,         1'b1, -1, 47, 1};
    vecs[5] = '{1'b0, 32'h0,          16'd1, 0, 1, 32'h0,          32'h1,         1'b0, 24, 25, 1};

    bus.start = 1'b0; bus.num_blocks = '0; bus.ctr_load = 1'b0; bus.ctr_init = '0;
    bus.abort = 1'b0; bus.ks_ready = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_block_ctr", bus.block_ctr, 32'h1);
    check("rst_outputs", 32'({bus.core_load, bus.core_round_en, bus.core_diag, bus.core_finalize,
                              bus.ks_valid, bus.busy, bus.done, bus.ctr_overflow}), 32'h0);
    rst = 1'b1;
    step();

    // Single block, ks_ready high, cycle-exact strobes
    bus.ks_ready = 1'b1; bus.start = 1'b1; bus.num_blocks = 16'd1;
    step();
    bus.start = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      exp_vec = {c == 1, (c >= 2 && c <= 21), (c >= 2 && c <= 21 && ((c - 2) % 2 == 1)),
                 c == 22, c == 23, c == 24, c <= 24};
      got_vec = {bus.core_load, bus.core_round_en, bus.core_diag, bus.core_finalize,
                 bus.ks_valid, bus.done, bus.busy};
      check($sformatf("single_c%0d", c), 32'(got_vec), 32'(exp_vec));
      check($sformatf("single_ctr_c%0d", c), bus.block_ctr, (c <= 23) ? 32'h1 : 32'h2);
      step();
    end
    bus.ks_ready = 1'b0;

    // Directed table
    for (int i = 0; i < 6; i++) begin
      drive_run(vecs[i].pre, vecs[i].init, vecs[i].nblk, 100, vecs[i].stall);
      check($sformatf("tbl%0d_nblocks", i), 32'(q_got.size()), 32'(vecs[i].exp_n));
      if (q_got.size() > 0) check($sformatf("tbl%0d_first_ctr", i), q_got[0], vecs[i].exp_first);
      check($sformatf("tbl%0d_final_ctr", i), bus.block_ctr, vecs[i].exp_final);
      check($sformatf("tbl%0d_ovf", i), 32'(bus.ctr_overflow), 32'(vecs[i].exp_ovf));
      check($sformatf("tbl%0d_done_cyc", i), 32'(done_cyc), 32'(vecs[i].exp_done_cyc));
      check($sformatf("tbl%0d_end_cyc", i), 32'(end_cyc), 32'(vecs[i].exp_end_cyc));
      check($sformatf("tbl%0d_vfirst", i), 32'(v_first), 32'(vecs[i].exp_vfirst));
    end
    model_ctr = 32'h1;

    // Abort at round 7
    bus.start = 1'b1; bus.num_blocks = 16'd2;
    step();
    bus.start = 1'b0;
    repeat (8) step();
    check("abort_at_round7", 32'({bus.core_round_en, bus.core_diag}), 32'h3);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_round_en", 32'(bus.core_round_en), 32'h0);
    check("abort_busy", 32'(bus.busy), 32'h0);
    n = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.ks_valid || bus.busy || bus.done) n++;
      step();
    end
    check("abort_quiet", 32'(n), 32'h0);
    check("abort_ctr_kept", bus.block_ctr, model_ctr);

    // start together with abort is ignored; start with zero blocks is ignored
    bus.start = 1'b1; bus.num_blocks = 16'd1; bus.abort = 1'b1;
    step();
    bus.start = 1'b0; bus.abort = 1'b0;
    check("start_abort_ignored", 32'(bus.busy), 32'h0);
    bus.start = 1'b1; bus.num_blocks = 16'd0;
    step();
    bus.start = 1'b0;
    check("zero_start_busy", 32'(bus.busy), 32'h0);
    step();
    check("zero_start_busy2", 32'(bus.busy), 32'h0);

    // Abort during OUT with ks_ready high: no counter step, no done
    bus.start = 1'b1; bus.num_blocks = 16'd1;
    step();
    bus.start = 1'b0;
    repeat (22) step();
    check("out_reached", 32'(bus.ks_valid), 32'h1);
    bus.ks_ready = 1'b1; bus.abort = 1'b1;
    step();
    bus.ks_ready = 1'b0; bus.abort = 1'b0;
    check("out_abort_state", 32'({bus.ks_valid, bus.busy, bus.done}), 32'h0);
    check("out_abort_ctr", bus.block_ctr, model_ctr);

    // Reset while stalled in OUT
    bus.start = 1'b1; bus.num_blocks = 16'd1; bus.ctr_load = 1'b1; bus.ctr_init = 32'h40;
    step();
    bus.start = 1'b0; bus.ctr_load = 1'b0;
    repeat (25) step();
    check("rst_pre_valid", 32'(bus.ks_valid), 32'h1);
    check("rst_pre_ctr", bus.block_ctr, 32'h40);
    #2 rst = 1'b0;
    #1;
    check("rst_async_valid", 32'(bus.ks_valid), 32'h0);
    check("rst_async_ctr", bus.block_ctr, 32'h1);
    step();
    rst = 1'b1;
    step();
    drive_run(1'b0, 32'h0, 16'd1, 100, 0);
    check("post_rst_first", (q_got.size() > 0) ? q_got[0] : 32'hDEAD_BEEF, 32'h1);
    check("post_rst_done", 32'(done_cyc), 32'd24);
    check("post_rst_final", bus.block_ctr, 32'h2);
    model_ctr = 32'h2;

    // Randomized runs against the counter model
    for (int r = 0; r < 20; r++) begin
      pre = ($urandom_range(1) == 1);
      init = ($urandom_range(3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(3))) : $urandom;
      n = $urandom_range(1, 4);
      pct = $urandom_range(30, 100);
      model_run(pre ? init : model_ctr, n);
      drive_run(pre, init, 16'(n), pct, 0);
      check($sformatf("rnd%0d_nblocks", r), 32'(q_got.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size() && k < q_got.size(); k++)
        check($sformatf("rnd%0d_blk%0d_ctr", r, k), q_got[k], exp_q[k]);
      check($sformatf("rnd%0d_ovf", r), 32'(bus.ctr_overflow), 32'(exp_ovf));
      check($sformatf("rnd%0d_done", r), 32'(done_cnt), exp_ovf ? 32'd0 : 32'd1);
      check($sformatf("rnd%0d_final_ctr", r), bus.block_ctr, exp_final);
      model_ctr = exp_final;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chacha20_block_sequencer.md
Name: chacha20_block_sequencer

Overview:
Control FSM that drives one iterative ChaCha20 block core to produce a run of consecutive keystream blocks. It owns the 32-bit block counter, steps the core through load, 20 rounds and the final feed-forward add, and hands each finished block downstream over a valid/ready handshake. It sits between the host command interface and the ChaCha20 round datapath. The core processes one column or diagonal round per cycle.

Parameters:
CTR_W, 32, block counter width
NBLK_W, 16, width of the requested block-count field
ROUNDS, 20, rounds per block; must be even; one round per cycle

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
start  input  1  command strobe; accepted only in IDLE
num_blocks  input  NBLK_W  blocks to generate; sampled on accepted start
ctr_load  input  1  in IDLE, load ctr_init into the counter
ctr_init  input  CTR_W  counter preload value
abort  input  1  synchronous abort from any state
core_load  output  1  load core state (key, nonce, counter)
core_round_en  output  1  core performs one round this cycle
core_diag  output  1  0 = column round, 1 = diagonal round
core_finalize  output  1  core adds the input state to the working state
block_ctr  output  CTR_W  counter value presented to the core
ks_valid  output  1  keystream block available
ks_ready  input  1  downstream accepts the block
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the run completes
ctr_overflow  output  1  sticky error flag

Behaviour:
- Reset values: all outputs 0 except block_ctr = 1; FSM in IDLE; remaining-block count = 0.
- States: IDLE, LOAD, ROUND, FINAL, OUT, DONE.
- IDLE: on start with num_blocks != 0, latch num_blocks, clear ctr_overflow, go to LOAD. A start with num_blocks == 0 is ignored, with no state change. ctr_load in IDLE sets block_ctr = ctr_init on the next edge. ctr_load outside IDLE is ignored. If start and ctr_load are both high, the load takes effect and the first block uses ctr_init.
- LOAD: 1 cycle; core_load = 1. Next state is ROUND.
- ROUND: ROUNDS cycles. core_round_en = 1. The round index r runs 0..ROUNDS-1 and core_diag = r[0]. After r = ROUNDS-1, go to FINAL.
- FINAL: 1 cycle; core_finalize = 1. Next state is OUT.
- OUT: ks_valid = 1 until a ks_valid & ks_ready handshake. ks_valid does not drop before the handshake. The counter is frozen while stalled.
- On the OUT handshake:
  - Decrement the remaining-block count.
  - Increment block_ctr, modulo 2^CTR_W.
  - If blocks remain and block_ctr was all ones before the increment, set ctr_overflow and go to IDLE; done is not pulsed.
  - Otherwise, if blocks remain, go to LOAD; if none remain, go to DONE.
- DONE: 1 cycle; done = 1. Next state is IDLE.
- Latency from start accepted at cycle T: core_load at T+1, rounds at T+2..T+1+ROUNDS, finalize at T+2+ROUNDS, earliest ks_valid at T+3+ROUNDS. A zero-stall block takes ROUNDS+3 cycles.
- block_ctr is stable from LOAD through the OUT handshake.
- abort (highest priority after reset): the next state is IDLE from any state. All strobes deassert, and ks_valid drops even without a handshake. block_ctr keeps its current value, and no done pulse is issued. A start in the same cycle as abort is ignored.
- Reset mid-operation: immediate return to the reset values, including block_ctr = 1.
- All outputs are registered or decoded from the state register only; there is no combinational path from ks_ready to ks_valid.

Decomposition:
- Shared package chacha20_pkg holds:
  - the state encoding (IDLE..DONE);
  - CHACHA_ROUNDS = 20;
  - CTR_RESET_VAL = 1;
  - the CHACHA constant words used by the core.
- Sub-module chacha20_block_ctr: a CTR_W counter with reset-to-1, sync load, an increment enable and a wrap flag (all-ones detect). The sequencer instantiates it.

Test Plan:
- Single block, ks_ready tied high:
  - Stimulus: start at cycle 0 with num_blocks = 1.
  - Response: core_load at cycle 1; core_round_en at cycles 2–21 with core_diag alternating 0,1; core_finalize at cycle 22; ks_valid at cycle 23; done at cycle 24.
  - block_ctr is 1 during the run and 2 afterwards.
- Backpressure:
  - Stimulus: num_blocks = 2 and ks_ready low for 5 cycles on the first block.
  - Response: ks_valid held for 6 cycles and block_ctr frozen at 1; the second block uses block_ctr = 2; done one cycle after the second handshake.
- Preload:
  - Stimulus: ctr_load with ctr_init = 0x10, then start with num_blocks = 3.
  - Response: the blocks use block_ctr 0x10, 0x11, 0x12; final value 0x13.
- Overflow:
  - Stimulus: ctr_init = 0xFFFFFFFF, num_blocks = 2.
  - Response: the first block is delivered; after its handshake ctr_overflow = 1, the FSM is in IDLE, done is never pulsed, and block_ctr = 0.
- Abort and ignored start:
  - Stimulus: abort at round 7.
  - Response: core_round_en low next cycle, busy = 0, no ks_valid.
  - Stimulus: start with num_blocks = 0.
  - Response: busy stays 0.
- Reset mid-run:
  - Stimulus: rst low in OUT while stalled.
  - Response: ks_valid = 0 immediately (asynchronous) and block_ctr = 1; a new start runs normally.
